// File: rtl/im_dumper.sv
`default_nettype none
// ============================================================================
//  Module      : im_dumper
//  Description : Instruction-memory readback engine. On an accepted start
//                command it reads `count` 32-bit words beginning at `base`
//                and streams each one to the UART transmitter as four bytes,
//                most significant byte first. Reads are clamped so that no
//                address at or beyond SIZE is ever fetched.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1   system clock, rising edge
//    rst       in   1   asynchronous active-high reset
//    enable    in   1   global enable; low freezes all state, gates tx_v/done
//    start     in   1   one-cycle command pulse, honoured only when idle
//    base      in  32   first word address, captured on accepted start
//    count     in  32   number of words requested, captured on accepted start
//    im_ra     out 32   instruction memory read address (registered)
//    im_rd     in  32   instruction memory read data (combinational of im_ra)
//    tx_d      out  8   byte presented to the transmitter
//    tx_v      out  1   tx_d valid
//    tx_ready  in   1   transmitter accepts the presented byte this cycle
//    busy      out  1   engine is not idle
//    done      out  1   one-cycle pulse at the end of every accepted command
// ============================================================================
module im_dumper #(
    parameter int SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start,
    input  logic [31:0] base,
    input  logic [31:0] count,
    output logic [31:0] im_ra,
    input  logic [31:0] im_rd,
    output logic [7:0]  tx_d,
    output logic        tx_v,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_FETCH = 3'd1;
    localparam logic [2:0] C_ST_SEND  = 3'd2;
    localparam logic [2:0] C_ST_NEXT  = 3'd3;
    localparam logic [2:0] C_ST_DONE  = 3'd4;

    localparam logic [31:0] C_SIZE = 32'(SIZE);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]  state_q,     state_d;
    logic [31:0] im_ra_q,     im_ra_d;
    logic [31:0] word_q,      word_d;
    logic [31:0] remaining_q, remaining_d;
    logic [1:0]  byte_idx_q,  byte_idx_d;

    // ------------------------------------------------------------------------
    // Shared combinational terms
    // ------------------------------------------------------------------------
    logic        w_accept;     // start command taken this cycle
    logic        w_empty_cmd;  // accepted command transfers no words
    logic        w_xfer;       // a byte leaves this cycle
    logic [31:0] w_ra_inc;     // next sequential word address
    logic        w_ra_at_end;  // next address would fall off the memory
    logic        w_last_word;  // word just sent closes the command

    assign w_accept    = enable && start && (state_q == C_ST_IDLE);
    assign w_empty_cmd = (count == 32'd0) || (base >= C_SIZE);
    assign w_xfer      = tx_v && tx_ready;
    assign w_ra_inc    = im_ra_q + 32'd1;
    assign w_ra_at_end = (w_ra_inc == C_SIZE);
    assign w_last_word = (remaining_q == 32'd1) || w_ra_at_end;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic. With enable low every state simply holds.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                C_ST_IDLE: begin
                    if (start) begin
                        state_d = w_empty_cmd ? C_ST_DONE : C_ST_FETCH;
                    end
                end
                C_ST_FETCH: begin
                    state_d = C_ST_SEND;
                end
                C_ST_SEND: begin
                    if (tx_ready && (byte_idx_q == 2'd3)) begin
                        state_d = C_ST_NEXT;
                    end
                end
                C_ST_NEXT: begin
                    state_d = w_last_word ? C_ST_DONE : C_ST_FETCH;
                end
                C_ST_DONE: begin
                    state_d = C_ST_IDLE;
                end
                default: begin
                    state_d = C_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. tx_d always shows the top byte of the shift register, so
    // it cannot change while a byte waits for tx_ready (the shift only occurs
    // on a transfer) or while enable is low (nothing moves).
    // ------------------------------------------------------------------------
    always_comb begin
        tx_v  = (state_q == C_ST_SEND) && enable;
        done  = (state_q == C_ST_DONE) && enable;
        busy  = (state_q != C_ST_IDLE);
        tx_d  = word_q[31:24];
        im_ra = im_ra_q;
    end

    // ------------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------------
    always_comb begin
        im_ra_d     = im_ra_q;
        word_d      = word_q;
        remaining_d = remaining_q;
        byte_idx_d  = byte_idx_q;

        if (enable) begin
            case (state_q)
                C_ST_IDLE: begin
                    if (w_accept) begin
                        im_ra_d     = base;
                        remaining_d = count;
                    end
                end
                C_ST_FETCH: begin
                    // Only point at which memory data is captured.
                    word_d     = im_rd;
                    byte_idx_d = 2'd0;
                end
                C_ST_SEND: begin
                    if (w_xfer) begin
                        word_d     = {word_q[23:0], 8'h00};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
                C_ST_NEXT: begin
                    remaining_d = remaining_q - 32'd1;
                    // Stop the address at the last word rather than stepping
                    // onto SIZE, so im_ra never presents an out-of-range
                    // address once a legal dump is underway.
                    if (!w_ra_at_end) begin
                        im_ra_d = w_ra_inc;
                    end
                end
                C_ST_DONE: begin
                    im_ra_d = 32'd0;
                end
                default: begin
                    im_ra_d = im_ra_q;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_ra_q     <= 32'd0;
            word_q      <= 32'd0;
            remaining_q <= 32'd0;
            byte_idx_q  <= 2'd0;
        end else begin
            im_ra_q     <= im_ra_d;
            word_q      <= word_d;
            remaining_q <= remaining_d;
            byte_idx_q  <= byte_idx_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/im_dumper.md
# im_dumper

Reads a range of 32-bit words from the instruction memory and streams them out as bytes to the UART transmitter, most significant byte first. It is the readback counterpart of the UART program loader, so a host can verify a loaded image byte-for-byte. It sits between the instruction memory's read port and the UART TX byte interface. It is started by a one-cycle command pulse from the debug/control logic.

## Interface
Parameters:
- SIZE, 1024, instruction memory depth in 32-bit words; addresses ≥ SIZE are never read.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  global enable; when low, all state holds and tx_v is forced 0.
- start  input  1  one-cycle command; sampled only in IDLE with enable=1.
- base  input  32  first word address, sampled on accepted start.
- count  input  32  number of words requested, sampled on accepted start.
- im_ra  output  32  memory read address, registered.
- im_rd  input  32  memory read data, combinational from im_ra (same cycle).
- tx_d  output  8  byte to transmit.
- tx_v  output  1  tx_d valid.
- tx_ready  input  1  transmitter accepts a byte this cycle.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse at the end of every accepted command.

## Operation
- Reset values: state=IDLE, im_ra=0, word=0, remaining=0, byte_idx=0, tx_d=0, tx_v=0, busy=0, done=0.
- A byte is transferred when tx_v && tx_ready. tx_v = (state==SEND) && enable. tx_d = word[31:24].
- IDLE: on start && enable:
  - im_ra<=base, remaining<=count.
  - Go to DONE if count==0 or base≥SIZE; otherwise go to FETCH.
  - start is ignored in every other state.
- FETCH (1 cycle): word<=im_rd, byte_idx<=0, then go to SEND.
- SEND: on each transfer, word<=word<<8 and byte_idx<=byte_idx+1. The transfer with byte_idx==3 goes to NEXT.
  - tx_d must stay stable while tx_v=1 and tx_ready=0.
- NEXT (1 cycle): im_ra<=im_ra+1, remaining<=remaining-1.
  - Go to DONE if remaining==1 or im_ra+1==SIZE; otherwise go to FETCH.
- DONE (1 cycle): done=1, im_ra<=0, then go to IDLE.
- Words sent = min(count, SIZE−base) when base<SIZE, else 0. Address never wraps past SIZE−1.
- remaining is a 32-bit down-counter. count up to 2^32−1 is legal and is always bounded by the SIZE clamp.
- enable=0 freezes state and all registers, tx_v=0. A byte that was presented but not yet accepted is re-presented unchanged once enable returns. done is not asserted while enable=0.
- rst mid-operation returns the block to its reset values immediately. No partial done is produced. The next start behaves normally.

## Timing
- Accepted start in cycle 0: FETCH in cycle 1, tx_v first high in cycle 2.
- With tx_ready held 1, each word takes 6 cycles: FETCH, 4×SEND, NEXT. Bytes are on cycles 2–5, 8–11, …
- N words with tx_ready=1: done is high in cycle 6N+1, IDLE in cycle 6N+2. busy is high in cycles 1 to 6N+1.
- count==0 or base≥SIZE: DONE in cycle 1 (done=1), IDLE in cycle 2. tx_v never rises.
- Each cycle of tx_ready=0 during SEND adds exactly one cycle. There is no byte loss or duplication.
- im_rd is sampled only in FETCH. Memory writes during a dump affect only words not yet fetched.

## Test plan
- mem[5]=0xDEADBEEF, start base=5 count=1, tx_ready=1 -> tx_d on cycles 2–5 is DE, AD, BE, EF; done=1 in cycle 7; busy=0 in cycle 8; im_ra=0 afterwards.
- mem[0..2]=0x01020304, 0x05060708, 0x090A0B0C, count=3, tx_ready toggling 1/0 every cycle -> exactly 12 bytes 01…0C in order; tx_d stable across every stalled cycle; done only after the 12th transfer.
- SIZE=1024, base=1022, count=5 -> exactly 8 bytes from words 1022 and 1023; im_ra never presents 1024; then done.
- count=0, and separately base=1024 count=4 -> done pulses in cycle 1, tx_v stays 0 throughout, busy high for 1 cycle only; a start asserted while busy is ignored.
- enable dropped for 3 cycles while the byte AD (second byte of 0xDEADBEEF) is pending -> tx_v=0 for those cycles; AD is then re-sent once, followed by BE, EF; total latency +3 cycles.
- rst asserted during the second word of a count=4 dump -> all outputs reset values asynchronously; a new dump base=0 count=1 then produces exactly 4 correct bytes and one done.
